pipe_ctrl: RTL

- Pipeline control unit for the 3-stage RV32I core (if → if_id → id → id_ex → ex).
- Holds the PC and pipeline registers, or inserts bubbles, for three cases: load-use hazards, taken jumps/branches resolved in EX, and multicycle EX operations.
- Contains a small FSM and counters, so a stall or flush can span several cycles.
- Sole source of hold/flush strobes for pc_reg, if_id and id_ex.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 3-stage RV32I core: load-use stalls, EX-resolved
// redirects with multi-cycle flush, and freezing the front end for multicycle EX ops.
module pipe_ctrl #(
   parameter int MC_LAT    = 4,
   parameter int FLUSH_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_rd_wen,
   input  logic        ex_is_load,
   input  logic        ex_jump_en,
   input  logic [31:0] ex_jump_addr,
   input  logic        ex_mc_start,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o,
   output logic        hold_pc,
   output logic        hold_if_id,
   output logic        hold_id_ex,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        mc_done,
   output logic [1:0]  state_o
);

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] FLUSH   = 2'd1;
   localparam logic [1:0] MC_WAIT = 2'd2;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);
   localparam logic [3:0] MC_INIT    = 4'(MC_LAT - 2);

   logic [1:0] state, state_nxt;
   logic [3:0] flush_cnt, flush_cnt_nxt;
   logic [3:0] mc_cnt, mc_cnt_nxt;
   logic       load_use;

   // x0 is hardwired zero, so a load targeting it can never feed a dependent op
   assign load_use = ex_is_load & ex_rd_wen & (ex_rd_addr != 5'd0) &
                     ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         flush_cnt <= 4'd0;
         mc_cnt    <= 4'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         mc_cnt    <= mc_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      mc_cnt_nxt    = mc_cnt;
      case (state)
         RUN: begin
            if (ex_jump_en) begin
               if (FLUSH_CYC > 1) begin
                  state_nxt     = FLUSH;
                  flush_cnt_nxt = FLUSH_INIT;
               end
            end else if (ex_mc_start) begin
               state_nxt  = MC_WAIT;
               mc_cnt_nxt = MC_INIT;
            end
         end
         FLUSH: begin
            if (ex_jump_en) begin
               flush_cnt_nxt = FLUSH_INIT;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
               if (flush_cnt == 4'd1) state_nxt = RUN;
            end
         end
         MC_WAIT: begin
            if (mc_cnt == 4'd0) state_nxt = RUN;
            else                mc_cnt_nxt = mc_cnt - 4'd1;
         end
         default: begin
            state_nxt     = RUN;
            flush_cnt_nxt = 4'd0;
            mc_cnt_nxt    = 4'd0;
         end
      endcase
   end

   // Strobes are gated by rst_n so a mid-sequence reset drops them without waiting for a clock
   always_comb begin
      jump_en_o   = 1'b0;
      jump_addr_o = 32'd0;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      mc_done     = 1'b0;
      if (rst_n) begin
         case (state)
            RUN: begin
               if (ex_jump_en) begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = ex_jump_addr;
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (ex_mc_start) begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
               end else if (load_use) begin
                  hold_pc     = 1'b1;
                  hold_if_id  = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            FLUSH: begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               if (ex_jump_en) begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = ex_jump_addr;
               end
            end
            MC_WAIT: begin
               if (mc_cnt == 4'd0) begin
                  mc_done = 1'b1;
               end else begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign state_o = state;

endmodule
